// File: rtl/instruction_encoder.sv
// ============================================================================
// Module   : instruction_encoder
// Function : symbolic (CMD, ADDRESS, operand) request -> 6502 machine-code bytes
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_encoder #(
    parameter int CMD_W          = 6,
    parameter int ADDR_W         = 4,
    parameter bit REJECT_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [15:0]       in_operand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_first,
    output logic              out_last,
    output logic              err_illegal,
    output logic              busy
);

    localparam logic [CMD_W-1:0]
        C_ADC = CMD_W'(0),  C_AND = CMD_W'(1),  C_ASL = CMD_W'(2),  C_BCC = CMD_W'(3),
        C_BCS = CMD_W'(4),  C_BEQ = CMD_W'(5),  C_BIT = CMD_W'(6),  C_BMI = CMD_W'(7),
        C_BNE = CMD_W'(8),  C_BPL = CMD_W'(9),  C_BRK = CMD_W'(10), C_BVC = CMD_W'(11),
        C_BVS = CMD_W'(12), C_CLC = CMD_W'(13), C_CLD = CMD_W'(14), C_CLI = CMD_W'(15),
        C_CLV = CMD_W'(16), C_CMP = CMD_W'(17), C_CPX = CMD_W'(18), C_CPY = CMD_W'(19),
        C_DEC = CMD_W'(20), C_DEX = CMD_W'(21), C_DEY = CMD_W'(22), C_EOR = CMD_W'(23),
        C_INC = CMD_W'(24), C_INX = CMD_W'(25), C_INY = CMD_W'(26), C_JMP = CMD_W'(27),
        C_JSR = CMD_W'(28), C_LDA = CMD_W'(29), C_LDX = CMD_W'(30), C_LDY = CMD_W'(31),
        C_LSR = CMD_W'(32), C_NOP = CMD_W'(33), C_ORA = CMD_W'(34), C_PHA = CMD_W'(35),
        C_PHP = CMD_W'(36), C_PLA = CMD_W'(37), C_PLP = CMD_W'(38), C_ROL = CMD_W'(39),
        C_ROR = CMD_W'(40), C_RTI = CMD_W'(41), C_RTS = CMD_W'(42), C_SBC = CMD_W'(43),
        C_SEC = CMD_W'(44), C_SED = CMD_W'(45), C_SEI = CMD_W'(46), C_STA = CMD_W'(47),
        C_STX = CMD_W'(48), C_STY = CMD_W'(49), C_TAX = CMD_W'(50), C_TAY = CMD_W'(51),
        C_TSX = CMD_W'(52), C_TXA = CMD_W'(53), C_TXS = CMD_W'(54), C_TYA = CMD_W'(55);

    localparam logic [ADDR_W-1:0]
        A_IMPL = ADDR_W'(0), A_ACC  = ADDR_W'(1),  A_IMM  = ADDR_W'(2),  A_ZPG  = ADDR_W'(3),
        A_ZPGX = ADDR_W'(4), A_ZPGY = ADDR_W'(5),  A_ABS  = ADDR_W'(6),  A_ABSX = ADDR_W'(7),
        A_ABSY = ADDR_W'(8), A_IND  = ADDR_W'(9),  A_XIND = ADDR_W'(10), A_INDY = ADDR_W'(11),
        A_REL  = ADDR_W'(12);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OP = 2'd1, S_LO = 2'd2, S_HI = 2'd3} state_t;

    state_t      r_state;
    logic [7:0]  r_lo, r_hi, r_out_byte;
    logic [1:0]  r_len;
    logic        r_in_ready, r_out_valid, r_first, r_last, r_err, r_busy;

    logic [2:0]  w_aaa, w_abbb, w_saaa, w_sbbb;
    logic        w_aok, w_sok, w_ok;
    logic [7:0]  w_op;
    logic [1:0]  w_len;

    // Regular opcode columns: ALU group is aaa_bbb_01, shift group is aaa_bbb_10.
    always_comb begin
        w_aaa = 3'd0; w_saaa = 3'd0; w_abbb = 3'd0; w_sbbb = 3'd0; w_aok = 1'b1; w_sok = 1'b1;
        case (in_cmd)
            C_AND: w_aaa = 3'd1;  C_EOR: w_aaa = 3'd2;  C_ADC: w_aaa = 3'd3;  C_STA: w_aaa = 3'd4;
            C_LDA: w_aaa = 3'd5;  C_CMP: w_aaa = 3'd6;  C_SBC: w_aaa = 3'd7;
            C_ROL: w_saaa = 3'd1; C_LSR: w_saaa = 3'd2; C_ROR: w_saaa = 3'd3;
            default: ;
        endcase
        case (in_addr)
            A_XIND: w_abbb = 3'd0; A_ZPG:  w_abbb = 3'd1; A_IMM:  w_abbb = 3'd2; A_ABS:  w_abbb = 3'd3;
            A_INDY: w_abbb = 3'd4; A_ZPGX: w_abbb = 3'd5; A_ABSY: w_abbb = 3'd6; A_ABSX: w_abbb = 3'd7;
            default: w_aok = 1'b0;
        endcase
        case (in_addr)
            A_ZPG:  w_sbbb = 3'd1; A_ACC:  w_sbbb = 3'd2; A_ABS:  w_sbbb = 3'd3;
            A_ZPGX: w_sbbb = 3'd5; A_ABSX: w_sbbb = 3'd7;
            default: w_sok = 1'b0;
        endcase
    end

    // {legal, opcode}; 9'h1xx marks a legal pair
    always_comb begin
        {w_ok, w_op} = {1'b0, 8'hEA};
        case (in_cmd)
            C_ORA, C_AND, C_EOR, C_ADC, C_LDA, C_CMP, C_SBC:
                {w_ok, w_op} = {w_aok, w_aaa, w_abbb, 2'b01};
            C_STA: {w_ok, w_op} = {w_aok && (in_addr != A_IMM), w_aaa, w_abbb, 2'b01};
            C_ASL, C_ROL, C_LSR, C_ROR: {w_ok, w_op} = {w_sok, w_saaa, w_sbbb, 2'b10};
            C_STX: case (in_addr)
                A_ZPG: {w_ok, w_op} = 9'h186; A_ZPGY: {w_ok, w_op} = 9'h196; A_ABS: {w_ok, w_op} = 9'h18E;
                default: ;
            endcase
            C_LDX: case (in_addr)
                A_IMM: {w_ok, w_op} = 9'h1A2; A_ZPG: {w_ok, w_op} = 9'h1A6; A_ZPGY: {w_ok, w_op} = 9'h1B6;
                A_ABS: {w_ok, w_op} = 9'h1AE; A_ABSY: {w_ok, w_op} = 9'h1BE;
                default: ;
            endcase
            C_DEC: case (in_addr)
                A_ZPG: {w_ok, w_op} = 9'h1C6; A_ZPGX: {w_ok, w_op} = 9'h1D6;
                A_ABS: {w_ok, w_op} = 9'h1CE; A_ABSX: {w_ok, w_op} = 9'h1DE;
                default: ;
            endcase
            C_INC: case (in_addr)
                A_ZPG: {w_ok, w_op} = 9'h1E6; A_ZPGX: {w_ok, w_op} = 9'h1F6;
                A_ABS: {w_ok, w_op} = 9'h1EE; A_ABSX: {w_ok, w_op} = 9'h1FE;
                default: ;
            endcase
            C_BIT: case (in_addr)
                A_ZPG: {w_ok, w_op} = 9'h124; A_ABS: {w_ok, w_op} = 9'h12C;
                default: ;
            endcase
            C_STY: case (in_addr)
                A_ZPG: {w_ok, w_op} = 9'h184; A_ZPGX: {w_ok, w_op} = 9'h194; A_ABS: {w_ok, w_op} = 9'h18C;
                default: ;
            endcase
            C_LDY: case (in_addr)
                A_IMM: {w_ok, w_op} = 9'h1A0; A_ZPG: {w_ok, w_op} = 9'h1A4; A_ZPGX: {w_ok, w_op} = 9'h1B4;
                A_ABS: {w_ok, w_op} = 9'h1AC; A_ABSX: {w_ok, w_op} = 9'h1BC;
                default: ;
            endcase
            C_CPY: case (in_addr)
                A_IMM: {w_ok, w_op} = 9'h1C0; A_ZPG: {w_ok, w_op} = 9'h1C4; A_ABS: {w_ok, w_op} = 9'h1CC;
                default: ;
            endcase
            C_CPX: case (in_addr)
                A_IMM: {w_ok, w_op} = 9'h1E0; A_ZPG: {w_ok, w_op} = 9'h1E4; A_ABS: {w_ok, w_op} = 9'h1EC;
                default: ;
            endcase
            C_JMP: case (in_addr)
                A_ABS: {w_ok, w_op} = 9'h14C; A_IND: {w_ok, w_op} = 9'h16C;
                default: ;
            endcase
            C_JSR: {w_ok, w_op} = {in_addr == A_ABS, 8'h20};
            C_BPL: {w_ok, w_op} = {in_addr == A_REL, 8'h10};
            C_BMI: {w_ok, w_op} = {in_addr == A_REL, 8'h30};
            C_BVC: {w_ok, w_op} = {in_addr == A_REL, 8'h50};
            C_BVS: {w_ok, w_op} = {in_addr == A_REL, 8'h70};
            C_BCC: {w_ok, w_op} = {in_addr == A_REL, 8'h90};
            C_BCS: {w_ok, w_op} = {in_addr == A_REL, 8'hB0};
            C_BNE: {w_ok, w_op} = {in_addr == A_REL, 8'hD0};
            C_BEQ: {w_ok, w_op} = {in_addr == A_REL, 8'hF0};
            C_BRK: {w_ok, w_op} = {in_addr == A_IMPL, 8'h00};
            C_PHP: {w_ok, w_op} = {in_addr == A_IMPL, 8'h08};
            C_CLC: {w_ok, w_op} = {in_addr == A_IMPL, 8'h18};
            C_PLP: {w_ok, w_op} = {in_addr == A_IMPL, 8'h28};
            C_SEC: {w_ok, w_op} = {in_addr == A_IMPL, 8'h38};
            C_RTI: {w_ok, w_op} = {in_addr == A_IMPL, 8'h40};
            C_PHA: {w_ok, w_op} = {in_addr == A_IMPL, 8'h48};
            C_CLI: {w_ok, w_op} = {in_addr == A_IMPL, 8'h58};
            C_RTS: {w_ok, w_op} = {in_addr == A_IMPL, 8'h60};
            C_PLA: {w_ok, w_op} = {in_addr == A_IMPL, 8'h68};
            C_SEI: {w_ok, w_op} = {in_addr == A_IMPL, 8'h78};
            C_DEY: {w_ok, w_op} = {in_addr == A_IMPL, 8'h88};
            C_TXA: {w_ok, w_op} = {in_addr == A_IMPL, 8'h8A};
            C_TYA: {w_ok, w_op} = {in_addr == A_IMPL, 8'h98};
            C_TXS: {w_ok, w_op} = {in_addr == A_IMPL, 8'h9A};
            C_TAY: {w_ok, w_op} = {in_addr == A_IMPL, 8'hA8};
            C_TAX: {w_ok, w_op} = {in_addr == A_IMPL, 8'hAA};
            C_CLV: {w_ok, w_op} = {in_addr == A_IMPL, 8'hB8};
            C_TSX: {w_ok, w_op} = {in_addr == A_IMPL, 8'hBA};
            C_INY: {w_ok, w_op} = {in_addr == A_IMPL, 8'hC8};
            C_DEX: {w_ok, w_op} = {in_addr == A_IMPL, 8'hCA};
            C_CLD: {w_ok, w_op} = {in_addr == A_IMPL, 8'hD8};
            C_INX: {w_ok, w_op} = {in_addr == A_IMPL, 8'hE8};
            C_NOP: {w_ok, w_op} = {in_addr == A_IMPL, 8'hEA};
            C_SED: {w_ok, w_op} = {in_addr == A_IMPL, 8'hF8};
            default: ;
        endcase
    end

    always_comb begin
        case (in_addr)
            A_IMPL, A_ACC:                w_len = 2'd1;
            A_ABS, A_ABSX, A_ABSY, A_IND: w_len = 2'd3;
            default:                      w_len = 2'd2;
        endcase
    end

    // r_last marks the final byte, so one out_ready handshake on it ends the instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_lo        <= 8'h00;
            r_hi        <= 8'h00;
            r_len       <= 2'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_lo <= in_operand[7:0];
                    r_hi <= in_operand[15:8];
                    if (w_ok || !REJECT_ILLEGAL) begin
                        r_state     <= S_OP;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_first     <= 1'b1;
                        r_out_byte  <= w_ok ? w_op : 8'hEA;
                        r_len       <= w_ok ? w_len : 2'd1;
                        r_last      <= !w_ok || (w_len == 2'd1);
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: if (out_ready) begin
                    if (r_last) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_byte  <= 8'h00;
                        r_first     <= 1'b0;
                        r_last      <= 1'b0;
                    end else if (r_state == S_OP) begin
                        r_state    <= S_LO;
                        r_out_byte <= r_lo;
                        r_first    <= 1'b0;
                        r_last     <= (r_len == 2'd2);
                    end else begin
                        r_state    <= S_HI;
                        r_out_byte <= r_hi;
                        r_last     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_byte    = r_out_byte;
    assign out_first   = r_first;
    assign out_last    = r_last;
    assign err_illegal = r_err;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
// Module   : tb_instruction_encoder
// Function : directed self-checking bench for instruction_encoder
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_encoder;

    localparam logic [5:0]
        C_ADC = 6'd0,  C_AND = 6'd1,  C_ASL = 6'd2,  C_BCC = 6'd3,  C_BCS = 6'd4,  C_BEQ = 6'd5,
        C_BIT = 6'd6,  C_BMI = 6'd7,  C_BNE = 6'd8,  C_BPL = 6'd9,  C_BRK = 6'd10, C_BVC = 6'd11,
        C_BVS = 6'd12, C_CLC = 6'd13, C_CLD = 6'd14, C_CLI = 6'd15, C_CLV = 6'd16, C_CMP = 6'd17,
        C_CPX = 6'd18, C_CPY = 6'd19, C_DEC = 6'd20, C_DEX = 6'd21, C_DEY = 6'd22, C_EOR = 6'd23,
        C_INC = 6'd24, C_INX = 6'd25, C_INY = 6'd26, C_JMP = 6'd27, C_JSR = 6'd28, C_LDA = 6'd29,
        C_LDX = 6'd30, C_LDY = 6'd31, C_LSR = 6'd32, C_NOP = 6'd33, C_ORA = 6'd34, C_PHA = 6'd35,
        C_PHP = 6'd36, C_PLA = 6'd37, C_PLP = 6'd38, C_ROL = 6'd39, C_ROR = 6'd40, C_RTI = 6'd41,
        C_RTS = 6'd42, C_SBC = 6'd43, C_SEC = 6'd44, C_SED = 6'd45, C_SEI = 6'd46, C_STA = 6'd47,
        C_STX = 6'd48, C_STY = 6'd49, C_TAX = 6'd50, C_TAY = 6'd51, C_TSX = 6'd52, C_TXA = 6'd53,
        C_TXS = 6'd54, C_TYA = 6'd55;
    localparam logic [3:0]
        A_IMPL = 4'd0, A_ACC = 4'd1, A_IMM = 4'd2, A_ZPG = 4'd3, A_ZPGX = 4'd4, A_ZPGY = 4'd5,
        A_ABS = 4'd6, A_ABSX = 4'd7, A_ABSY = 4'd8, A_IND = 4'd9, A_XIND = 4'd10, A_INDY = 4'd11,
        A_REL = 4'd12;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [5:0]  in_cmd;
    logic [3:0]  in_addr;
    logic [15:0] in_operand;
    logic        in_ready, out_valid, out_first, out_last, err_illegal, busy;
    logic [7:0]  out_byte;
    logic        n_in_ready, n_out_valid, n_out_first, n_out_last, n_err_illegal, n_busy;
    logic [7:0]  n_out_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.CMD_W(6), .ADDR_W(4), .REJECT_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .in_addr(in_addr), .in_operand(in_operand), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_first(out_first), .out_last(out_last),
        .err_illegal(err_illegal), .busy(busy));

    instruction_encoder #(.CMD_W(6), .ADDR_W(4), .REJECT_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_cmd(in_cmd),
        .in_addr(in_addr), .in_operand(in_operand), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_byte(n_out_byte), .out_first(n_out_first), .out_last(n_out_last),
        .err_illegal(n_err_illegal), .busy(n_busy));

    // Reference decoder: opcode -> {legal, cmd, addr}
    function automatic logic [10:0] dec(input logic [7:0] op);
        case (op)
            8'h69: dec = {1'b1, C_ADC, A_IMM};  8'h65: dec = {1'b1, C_ADC, A_ZPG};  8'h75: dec = {1'b1, C_ADC, A_ZPGX};
            8'h6D: dec = {1'b1, C_ADC, A_ABS};  8'h7D: dec = {1'b1, C_ADC, A_ABSX}; 8'h79: dec = {1'b1, C_ADC, A_ABSY};
            8'h61: dec = {1'b1, C_ADC, A_XIND}; 8'h71: dec = {1'b1, C_ADC, A_INDY};
            8'h29: dec = {1'b1, C_AND, A_IMM};  8'h25: dec = {1'b1, C_AND, A_ZPG};  8'h35: dec = {1'b1, C_AND, A_ZPGX};
            8'h2D: dec = {1'b1, C_AND, A_ABS};  8'h3D: dec = {1'b1, C_AND, A_ABSX}; 8'h39: dec = {1'b1, C_AND, A_ABSY};
            8'h21: dec = {1'b1, C_AND, A_XIND}; 8'h31: dec = {1'b1, C_AND, A_INDY};
            8'h49: dec = {1'b1, C_EOR, A_IMM};  8'h45: dec = {1'b1, C_EOR, A_ZPG};  8'h55: dec = {1'b1, C_EOR, A_ZPGX};
            8'h4D: dec = {1'b1, C_EOR, A_ABS};  8'h5D: dec = {1'b1, C_EOR, A_ABSX}; 8'h59: dec = {1'b1, C_EOR, A_ABSY};
            8'h41: dec = {1'b1, C_EOR, A_XIND}; 8'h51: dec = {1'b1, C_EOR, A_INDY};
            8'h09: dec = {1'b1, C_ORA, A_IMM};  8'h05: dec = {1'b1, C_ORA, A_ZPG};  8'h15: dec = {1'b1, C_ORA, A_ZPGX};
            8'h0D: dec = {1'b1, C_ORA, A_ABS};  8'h1D: dec = {1'b1, C_ORA, A_ABSX}; 8'h19: dec = {1'b1, C_ORA, A_ABSY};
            8'h01: dec = {1'b1, C_ORA, A_XIND}; 8'h11: dec = {1'b1, C_ORA, A_INDY};
            8'hA9: dec = {1'b1, C_LDA, A_IMM};  8'hA5: dec = {1'b1, C_LDA, A_ZPG};  8'hB5: dec = {1'b1, C_LDA, A_ZPGX};
            8'hAD: dec = {1'b1, C_LDA, A_ABS};  8'hBD: dec = {1'b1, C_LDA, A_ABSX}; 8'hB9: dec = {1'b1, C_LDA, A_ABSY};
            8'hA1: dec = {1'b1, C_LDA, A_XIND}; 8'hB1: dec = {1'b1, C_LDA, A_INDY};
            8'hC9: dec = {1'b1, C_CMP, A_IMM};  8'hC5: dec = {1'b1, C_CMP, A_ZPG};  8'hD5: dec = {1'b1, C_CMP, A_ZPGX};
            8'hCD: dec = {1'b1, C_CMP, A_ABS};  8'hDD: dec = {1'b1, C_CMP, A_ABSX}; 8'hD9: dec = {1'b1, C_CMP, A_ABSY};
            8'hC1: dec = {1'b1, C_CMP, A_XIND}; 8'hD1: dec = {1'b1, C_CMP, A_INDY};
            8'hE9: dec = {1'b1, C_SBC, A_IMM};  8'hE5: dec = {1'b1, C_SBC, A_ZPG};  8'hF5: dec = {1'b1, C_SBC, A_ZPGX};
            8'hED: dec = {1'b1, C_SBC, A_ABS};  8'hFD: dec = {1'b1, C_SBC, A_ABSX}; 8'hF9: dec = {1'b1, C_SBC, A_ABSY};
            8'hE1: dec = {1'b1, C_SBC, A_XIND}; 8'hF1: dec = {1'b1, C_SBC, A_INDY};
            8'h85: dec = {1'b1, C_STA, A_ZPG};  8'h95: dec = {1'b1, C_STA, A_ZPGX}; 8'h8D: dec = {1'b1, C_STA, A_ABS};
            8'h9D: dec = {1'b1, C_STA, A_ABSX}; 8'h99: dec = {1'b1, C_STA, A_ABSY}; 8'h81: dec = {1'b1, C_STA, A_XIND};
            8'h91: dec = {1'b1, C_STA, A_INDY};
            8'h0A: dec = {1'b1, C_ASL, A_ACC};  8'h06: dec = {1'b1, C_ASL, A_ZPG};  8'h16: dec = {1'b1, C_ASL, A_ZPGX};
            8'h0E: dec = {1'b1, C_ASL, A_ABS};  8'h1E: dec = {1'b1, C_ASL, A_ABSX};
            8'h2A: dec = {1'b1, C_ROL, A_ACC};  8'h26: dec = {1'b1, C_ROL, A_ZPG};  8'h36: dec = {1'b1, C_ROL, A_ZPGX};
            8'h2E: dec = {1'b1, C_ROL, A_ABS};  8'h3E: dec = {1'b1, C_ROL, A_ABSX};
            8'h4A: dec = {1'b1, C_LSR, A_ACC};  8'h46: dec = {1'b1, C_LSR, A_ZPG};  8'h56: dec = {1'b1, C_LSR, A_ZPGX};
            8'h4E: dec = {1'b1, C_LSR, A_ABS};  8'h5E: dec = {1'b1, C_LSR, A_ABSX};
            8'h6A: dec = {1'b1, C_ROR, A_ACC};  8'h66: dec = {1'b1, C_ROR, A_ZPG};  8'h76: dec = {1'b1, C_ROR, A_ZPGX};
            8'h6E: dec = {1'b1, C_ROR, A_ABS};  8'h7E: dec = {1'b1, C_ROR, A_ABSX};
            8'h86: dec = {1'b1, C_STX, A_ZPG};  8'h96: dec = {1'b1, C_STX, A_ZPGY}; 8'h8E: dec = {1'b1, C_STX, A_ABS};
            8'hA2: dec = {1'b1, C_LDX, A_IMM};  8'hA6: dec = {1'b1, C_LDX, A_ZPG};  8'hB6: dec = {1'b1, C_LDX, A_ZPGY};
            8'hAE: dec = {1'b1, C_LDX, A_ABS};  8'hBE: dec = {1'b1, C_LDX, A_ABSY};
            8'hC6: dec = {1'b1, C_DEC, A_ZPG};  8'hD6: dec = {1'b1, C_DEC, A_ZPGX}; 8'hCE: dec = {1'b1, C_DEC, A_ABS};
            8'hDE: dec = {1'b1, C_DEC, A_ABSX};
            8'hE6: dec = {1'b1, C_INC, A_ZPG};  8'hF6: dec = {1'b1, C_INC, A_ZPGX}; 8'hEE: dec = {1'b1, C_INC, A_ABS};
            8'hFE: dec = {1'b1, C_INC, A_ABSX};
            8'h24: dec = {1'b1, C_BIT, A_ZPG};  8'h2C: dec = {1'b1, C_BIT, A_ABS};
            8'h84: dec = {1'b1, C_STY, A_ZPG};  8'h94: dec = {1'b1, C_STY, A_ZPGX}; 8'h8C: dec = {1'b1, C_STY, A_ABS};
            8'hA0: dec = {1'b1, C_LDY, A_IMM};  8'hA4: dec = {1'b1, C_LDY, A_ZPG};  8'hB4: dec = {1'b1, C_LDY, A_ZPGX};
            8'hAC: dec = {1'b1, C_LDY, A_ABS};  8'hBC: dec = {1'b1, C_LDY, A_ABSX};
            8'hC0: dec = {1'b1, C_CPY, A_IMM};  8'hC4: dec = {1'b1, C_CPY, A_ZPG};  8'hCC: dec = {1'b1, C_CPY, A_ABS};
            8'hE0: dec = {1'b1, C_CPX, A_IMM};  8'hE4: dec = {1'b1, C_CPX, A_ZPG};  8'hEC: dec = {1'b1, C_CPX, A_ABS};
            8'h4C: dec = {1'b1, C_JMP, A_ABS};  8'h6C: dec = {1'b1, C_JMP, A_IND};  8'h20: dec = {1'b1, C_JSR, A_ABS};
            8'h10: dec = {1'b1, C_BPL, A_REL};  8'h30: dec = {1'b1, C_BMI, A_REL};  8'h50: dec = {1'b1, C_BVC, A_REL};
            8'h70: dec = {1'b1, C_BVS, A_REL};  8'h90: dec = {1'b1, C_BCC, A_REL};  8'hB0: dec = {1'b1, C_BCS, A_REL};
            8'hD0: dec = {1'b1, C_BNE, A_REL};  8'hF0: dec = {1'b1, C_BEQ, A_REL};
            8'h00: dec = {1'b1, C_BRK, A_IMPL}; 8'h08: dec = {1'b1, C_PHP, A_IMPL}; 8'h18: dec = {1'b1, C_CLC, A_IMPL};
            8'h28: dec = {1'b1, C_PLP, A_IMPL}; 8'h38: dec = {1'b1, C_SEC, A_IMPL}; 8'h40: dec = {1'b1, C_RTI, A_IMPL};
            8'h48: dec = {1'b1, C_PHA, A_IMPL}; 8'h58: dec = {1'b1, C_CLI, A_IMPL}; 8'h60: dec = {1'b1, C_RTS, A_IMPL};
            8'h68: dec = {1'b1, C_PLA, A_IMPL}; 8'h78: dec = {1'b1, C_SEI, A_IMPL}; 8'h88: dec = {1'b1, C_DEY, A_IMPL};
            8'h8A: dec = {1'b1, C_TXA, A_IMPL}; 8'h98: dec = {1'b1, C_TYA, A_IMPL}; 8'h9A: dec = {1'b1, C_TXS, A_IMPL};
            8'hA8: dec = {1'b1, C_TAY, A_IMPL}; 8'hAA: dec = {1'b1, C_TAX, A_IMPL}; 8'hB8: dec = {1'b1, C_CLV, A_IMPL};
            8'hBA: dec = {1'b1, C_TSX, A_IMPL}; 8'hC8: dec = {1'b1, C_INY, A_IMPL}; 8'hCA: dec = {1'b1, C_DEX, A_IMPL};
            8'hD8: dec = {1'b1, C_CLD, A_IMPL}; 8'hE8: dec = {1'b1, C_INX, A_IMPL}; 8'hEA: dec = {1'b1, C_NOP, A_IMPL};
            8'hF8: dec = {1'b1, C_SED, A_IMPL};
            default: dec = 11'd0;
        endcase
    endfunction

    // Present one request; returns #1 after the edge on which it was offered.
    task automatic send(input logic [5:0] c, input logic [3:0] a, input logic [15:0] op);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_cmd = c; in_addr = a; in_operand = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // With out_ready high, capture the presented byte and let it transfer.
    task automatic take_byte(output logic [7:0] b, output logic f, output logic l, output bit to);
        int n = 0;
        to = 1'b0;
        while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (out_valid !== 1'b1) to = 1'b1;
        b = out_byte; f = out_first; l = out_last;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_cmd = 6'd0; in_addr = 4'd0; in_operand = 16'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_byte, out_first, out_last, err_illegal, busy} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b byte=%h f=%b l=%b err=%b busy=%b required 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_byte, out_first, out_last, err_illegal, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_lda_imm();
        out_ready = 1'b1;
        send(C_LDA, A_IMM, 16'h0042);
        checks++;
        if ({out_valid, out_byte, out_first, out_last, in_ready, busy} !== {1'b1, 8'hA9, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL lda_opcode: vld=%b byte=%h f=%b l=%b rdy=%b busy=%b required 1 a9 1 0 0 1",
                     out_valid, out_byte, out_first, out_last, in_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_byte, out_first, out_last, in_ready} !== {1'b1, 8'h42, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lda_operand: vld=%b byte=%h f=%b l=%b rdy=%b required 1 42 0 1 0",
                     out_valid, out_byte, out_first, out_last, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL lda_done: vld=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_three_byte();
        logic [5:0]  cs [3] = '{C_JMP, C_JMP, C_STA};
        logic [3:0]  as [3] = '{A_ABS, A_IND, A_ABSY};
        logic [15:0] os [3] = '{16'h1234, 16'h02FF, 16'h8000};
        logic [7:0]  ex [3][3] = '{'{8'h4C, 8'h34, 8'h12}, '{8'h6C, 8'hFF, 8'h02}, '{8'h99, 8'h00, 8'h80}};
        logic [7:0] b; logic f, l; bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(cs[i], as[i], os[i]);
            for (int k = 0; k < 3; k++) begin
                take_byte(b, f, l, to);
                checks++;
                if (to || b !== ex[i][k] || f !== (k == 0) || l !== (k == 2)) begin
                    errors++;
                    $display("FAIL abs_bytes[%0d][%0d]: timeout=%0d byte=%h f=%b l=%b required %h %b %b",
                             i, k, to, b, f, l, ex[i][k], k == 0, k == 2);
                end
            end
        end
    endtask

    task automatic test_single_byte();
        logic [5:0] cs [2] = '{C_NOP, C_ASL};
        logic [3:0] as [2] = '{A_IMPL, A_ACC};
        logic [7:0] ex [2] = '{8'hEA, 8'h0A};
        logic [7:0] b; logic f, l; bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(cs[i], as[i], 16'hFFFF);
            take_byte(b, f, l, to);
            checks++;
            if (to || b !== ex[i] || f !== 1'b1 || l !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_byte[%0d]: timeout=%0d byte=%h f=%b l=%b vld_after=%b rdy=%b required %h 1 1 0 1",
                         i, to, b, f, l, out_valid, in_ready, ex[i]);
            end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(C_STA, A_IMM, 16'h0011);
        checks++;
        if ({err_illegal, out_valid, in_ready, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL illegal_pulse: err=%b vld=%b rdy=%b busy=%b required 1 0 1 0",
                     err_illegal, out_valid, in_ready, busy);
        end
        checks++;
        if ({n_out_valid, n_out_byte, n_out_first, n_out_last, n_err_illegal} !== {1'b1, 8'hEA, 3'b110}) begin
            errors++;
            $display("FAIL illegal_as_nop: vld=%b byte=%h f=%b l=%b err=%b required 1 ea 1 1 0",
                     n_out_valid, n_out_byte, n_out_first, n_out_last, n_err_illegal);
        end
        @(posedge clk); #1;
        checks++;
        if ({err_illegal, out_valid, n_out_valid, n_in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL illegal_after: err=%b vld=%b nop_vld=%b nop_rdy=%b required 0 0 0 1",
                     err_illegal, out_valid, n_out_valid, n_in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ex [2] = '{8'hD0, 8'hFE};
        int idx = 0;
        int k = 0;
        out_ready = 1'b0;
        send(C_BNE, A_REL, 16'h00FE);
        while (idx < 2 && k < 12) begin
            out_ready = k[0];
            checks++;
            if (out_valid !== 1'b1 || out_byte !== ex[idx] || out_first !== (idx == 0) || out_last !== (idx == 1)) begin
                errors++;
                $display("FAIL stall_byte[cyc %0d]: vld=%b byte=%h f=%b l=%b required 1 %h %b %b",
                         k, out_valid, out_byte, out_first, out_last, ex[idx], idx == 0, idx == 1);
            end
            if (out_ready) idx++;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (idx != 2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: bytes=%0d vld=%b required 2 0", idx, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b; logic f, l; bit to;
        out_ready = 1'b1;
        send(C_LDX, A_ABS, 16'h1234);
        @(posedge clk); #1;
        checks++;
        if (out_byte !== 8'h34 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ldx_lo: byte=%h vld=%b required 34 1", out_byte, out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy, err_illegal} !== 4'b0100) begin
            errors++;
            $display("FAIL mid_reset: vld=%b rdy=%b busy=%b err=%b required 0 1 0 0",
                     out_valid, in_ready, busy, err_illegal);
        end
        send(C_LDY, A_ZPGX, 16'h0010);
        take_byte(b, f, l, to);
        checks++;
        if (to || b !== 8'hB4 || f !== 1'b1 || l !== 1'b0) begin
            errors++;
            $display("FAIL ldy_op: timeout=%0d byte=%h f=%b l=%b required b4 1 0", to, b, f, l);
        end
        take_byte(b, f, l, to);
        checks++;
        if (to || b !== 8'h10 || f !== 1'b0 || l !== 1'b1) begin
            errors++;
            $display("FAIL ldy_lo: timeout=%0d byte=%h f=%b l=%b required 10 0 1", to, b, f, l);
        end
        // Request offered together with reset is lost
        rst = 1'b1; in_valid = 1'b1; in_cmd = C_LDA; in_addr = A_IMM; in_operand = 16'h0055;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_with_valid: vld=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_sweep();
        int legal = 0;
        logic [7:0] bytes [3];
        logic [7:0] b; logic f, l; bit to;
        logic [15:0] op16;
        logic [10:0] d;
        int nb, explen;
        out_ready = 1'b1;
        for (int c = 0; c < 64; c++) begin
            for (int a = 0; a < 16; a++) begin
                op16 = {8'(c) ^ 8'hC3, 8'(a) ^ 8'h5A};
                explen = (a <= 1) ? 1 : ((a >= 6 && a <= 9) ? 3 : 2);
                send(6'(c), 4'(a), op16);
                if (err_illegal === 1'b1 && out_valid === 1'b0) begin
                    checks++;
                    if (dec_any(6'(c), 4'(a))) begin
                        errors++;
                        $display("FAIL sweep_rejected: cmd=%0d addr=%0d rejected, required legal", c, a);
                    end
                end else if (out_valid === 1'b1 && err_illegal === 1'b0) begin
                    legal++;
                    nb = 0; l = 1'b0; to = 1'b0;
                    bytes[0] = 8'h00; bytes[1] = 8'h00; bytes[2] = 8'h00;
                    while (!l && !to && nb < 3) begin
                        take_byte(b, f, l, to);
                        bytes[nb] = b;
                        nb++;
                    end
                    d = dec(bytes[0]);
                    checks++;
                    if (to || d !== {1'b1, 6'(c), 4'(a)} || nb != explen ||
                        (nb >= 2 && bytes[1] !== op16[7:0]) || (nb == 3 && bytes[2] !== op16[15:8])) begin
                        errors++;
                        $display("FAIL sweep_pair: cmd=%0d addr=%0d op=%h decodes %h len=%0d required %h len=%0d",
                                 c, a, bytes[0], d, nb, {1'b1, 6'(c), 4'(a)}, explen);
                    end
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_response: cmd=%0d addr=%0d err=%b vld=%b required exactly one set",
                             c, a, err_illegal, out_valid);
                end
            end
        end
        checks++;
        if (legal != 151) begin
            errors++;
            $display("FAIL sweep_count: legal pairs=%0d required 151", legal);
        end
    endtask

    // True when some opcode decodes to this pair.
    function automatic bit dec_any(input logic [5:0] c, input logic [3:0] a);
        logic [10:0] d;
        dec_any = 1'b0;
        for (int o = 0; o < 256; o++) begin
            d = dec(8'(o));
            if (d == {1'b1, c, a}) dec_any = 1'b1;
        end
    endfunction

    initial begin
        test_reset();
        test_lda_imm();
        test_three_byte();
        test_single_byte();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
